// File: rtl/pkt_pkg.sv
// Shared definitions for the packet framer and its egress neighbours.
package pkt_pkg;

  // Framer states: no packet open, packet collecting payload, trailer pending.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TRAIL = 2'd2
  } state_t;

  // The checksum lives at the data width so the trailer fits in one word.
  function automatic int unsigned csum_width(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/framer_oreg.sv
// One-entry output register with a req/ack output side; o_free says a load may happen now.
module framer_oreg #(
  parameter int unsigned dw = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_load,
  input  logic [dw-1:0] i_data,
  input  logic          i_last,
  input  logic          i_ack,
  output logic          o_req,
  output logic [dw-1:0] o_data,
  output logic          o_last,
  output logic          o_free
);

  logic          r_valid;
  logic [dw-1:0] r_data;
  logic          r_last;

  // Load wins over drain; the caller only loads when o_free is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ack) begin
      r_valid <= 1'b0;
    end
  end

  // Free when empty or when the held word leaves on this edge.
  always_comb begin
    o_free = ~r_valid | i_ack;
    o_req  = r_valid;
    o_data = r_data;
    o_last = r_last;
  end

endmodule

// File: rtl/pkt_framer.sv
// Groups a req/ack word stream into packets closed by a two's-complement checksum trailer.
module pkt_framer
  import pkt_pkg::*;
#(
  parameter int unsigned dw      = 8,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned TMO     = 8,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [dw-1:0] d_in,
  input  logic          req_in,
  output logic          ack_in,
  output logic [dw-1:0] d_out,
  output logic          req_out,
  output logic          last_out,
  input  logic          ack_out,
  output logic [CW-1:0] pkt_count
);

  localparam int unsigned SW   = csum_width(dw);
  localparam int unsigned CNTW = $clog2(PKT_LEN + 1);
  localparam int unsigned TW   = (TMO > 0) ? $clog2(TMO + 1) : 1;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PKT_LEN - 1);
  localparam logic [TW-1:0]   TMR_LAST = (TMO == 0) ? '0 : TW'(TMO - 1);

  state_t          r_state;
  logic [SW-1:0]   r_sum;
  logic [CNTW-1:0] r_cnt;
  logic [TW-1:0]   r_tmr;
  logic [CW-1:0]   r_pkt_count;

  logic            w_free;
  logic            w_accept;
  logic            w_load;
  logic [dw-1:0]   w_load_data;
  logic            w_load_last;
  logic [dw-1:0]   w_trailer;

  // Input handshake and output-register load selection.
  always_comb begin
    ack_in      = w_free & (r_state != TRAIL);
    w_accept    = req_in & ack_in;
    w_trailer   = '0 - r_sum;
    w_load_last = (r_state == TRAIL);
    w_load      = w_accept | (w_load_last & w_free);
    w_load_data = w_load_last ? w_trailer : d_in;
  end

  // Packet FSM with checksum accumulator, payload counter and idle timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_tmr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sum   <= d_in;
            r_cnt   <= CNTW'(1);
            r_tmr   <= '0;
            r_state <= (PKT_LEN == 1) ? TRAIL : OPEN;
          end
        end
        OPEN: begin
          if (w_accept) begin
            // A word arriving on the expiry cycle still joins the packet.
            r_sum <= r_sum + d_in;
            r_cnt <= r_cnt + CNTW'(1);
            r_tmr <= '0;
            if (r_cnt == CNT_LAST) begin
              r_state <= TRAIL;
            end
          end else if ((TMO != 0) && (r_tmr == TMR_LAST)) begin
            r_state <= TRAIL;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        TRAIL: begin
          // Timer is frozen here; the trailer waits for room downstream.
          if (w_free) begin
            r_sum   <= '0;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Count trailers as they leave, not when they are formed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pkt_count <= '0;
    end else if (req_out && ack_out && last_out) begin
      r_pkt_count <= r_pkt_count + CW'(1);
    end
  end

  assign pkt_count = r_pkt_count;

  framer_oreg #(
    .dw(dw)
  ) u_oreg (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_load),
    .i_data (w_load_data),
    .i_last (w_load_last),
    .i_ack  (ack_out),
    .o_req  (req_out),
    .o_data (d_out),
    .o_last (last_out),
    .o_free (w_free)
  );

endmodule

// File: tb/tb_pkt_framer.sv
// Scoreboard bench for pkt_framer: packet-level reference model feeds an expected-word queue.
module tb_pkt_framer;

  localparam int unsigned DW = 8;
  localparam int unsigned PL = 4;
  localparam int unsigned TM = 8;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] d_in = '0;
  logic          req_in = 1'b0;
  logic          ack_in;
  logic [DW-1:0] d_out;
  logic          req_out;
  logic          last_out;
  logic          ack_out = 1'b1;
  logic [CW-1:0] pkt_count;

  pkt_framer #(
    .dw      (DW),
    .PKT_LEN (PL),
    .TMO     (TM),
    .CW      (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .d_in      (d_in),
    .req_in    (req_in),
    .ack_in    (ack_in),
    .d_out     (d_out),
    .req_out   (req_out),
    .last_out  (last_out),
    .ack_out   (ack_out),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   exp_pkts = 0;
  logic [7:0] last_trailer = '0;
  bit   rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: packets are lists of words; close on length or TM idle cycles.
  initial begin : model
    logic [7:0] pkt[$];
    int idle;
    idle = 0;
    forever begin
      @(negedge clk or negedge rstn);
      if (!rstn) begin
        exp_q.delete();
        pkt.delete();
        idle = 0;
      end else if (req_in && ack_in) begin
        pkt.push_back(d_in);
        exp_q.push_back('{d: d_in, l: 1'b0});
        idle = 0;
        if (pkt.size() == PL) begin
          int s;
          s = 0;
          foreach (pkt[i]) s += int'(pkt[i]);
          exp_q.push_back('{d: 8'((256 - (s % 256)) % 256), l: 1'b1});
          pkt.delete();
        end
      end else if (pkt.size() != 0) begin
        idle++;
        if (idle == TM) begin
          int s;
          s = 0;
          foreach (pkt[i]) s += int'(pkt[i]);
          exp_q.push_back('{d: 8'((256 - (s % 256)) % 256), l: 1'b1});
          pkt.delete();
          idle = 0;
        end
      end
    end
  end

  // Monitor: pops on every output transfer, checks hold-while-stalled and pkt_count.
  initial begin : monitor
    bit   hold_v;
    logic [9:0] hold;
    bit   cnt_pend;
    exp_t e;
    hold_v   = 1'b0;
    cnt_pend = 1'b0;
    forever begin
      @(negedge clk or negedge rstn);
      if (!rstn) begin
        hold_v   = 1'b0;
        cnt_pend = 1'b0;
        exp_pkts = 0;
      end else begin
        if (cnt_pend) check("pkt_count", 32'(pkt_count), 32'(exp_pkts % 65536));
        cnt_pend = 1'b0;
        if (hold_v) check("hold_stable", {22'd0, req_out, last_out, d_out}, {22'd0, hold});
        hold_v = req_out && !ack_out;
        hold   = {req_out, last_out, d_out};
        if (req_out && ack_out) begin
          check("exp_available", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("d_out", 32'(d_out), 32'(e.d));
            check("last_out", 32'(last_out), 32'(e.l));
            if (last_out) begin
              exp_pkts++;
              last_trailer = d_out;
              cnt_pend     = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n      = 0;
    d_in   = d;
    req_in = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_in && n < 200);
    check("send_accept", 32'(ack_in), 32'd1);
    @(posedge clk);
    #1;
    req_in = 1'b0;
    d_in   = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; asynchronous reset must clear outputs at once.
  task automatic rst_pulse();
    rstn = 1'b0;
    #1;
    check("rst_req_out", 32'(req_out), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_last_out", 32'(last_out), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    #1;
    rstn = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lows;
    int tot;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_out", 32'(req_out), 32'd0);
    check("reset_pkt_count", 32'(pkt_count), 32'd0);
    rstn = 1'b1;
    #1;
    check("reset_ack_in", 32'(ack_in), 32'd1);

    // Full packet back-to-back with one input bubble for the trailer.
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (!ack_in) lows++;
    end
    check("ack_in_bubble", 32'(lows), 32'd1);
    check("trailer_f6", 32'(last_trailer), 32'hF6);
    check("pkt_count_t1", 32'(pkt_count), 32'd1);

    // Idle timeout closes a partial packet after TM idle cycles.
    @(posedge clk); #1;
    rst_pulse();
    send(8'h10); send(8'h20);
    idle(8);
    check("tmo_not_early", 32'(req_out), 32'd0);
    idle(1);
    check("tmo_trailer", {22'd0, req_out, last_out, d_out}, {22'd0, 2'b11, 8'hD0});
    idle(1);
    check("pkt_count_t2", 32'(pkt_count), 32'd1);

    // Checksum wrap.
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    idle(4);
    check("trailer_wrap", 32'(last_trailer), 32'h04);
    tot = (4 * 255 + int'(last_trailer)) % 256;
    check("csum_zero", 32'(tot), 32'd0);

    // Downstream stall holds the word and blocks input.
    ack_out = 1'b0;
    send(8'h5A);
    repeat (4) begin
      @(negedge clk);
      check("stall_hold", {21'd0, req_out, ack_in, d_out}, {21'd0, 2'b10, 8'h5A});
    end
    @(posedge clk); #1;
    ack_out = 1'b1;
    @(negedge clk);
    check("stall_release_ack_in", 32'(ack_in), 32'd1);
    idle(14);

    // Accept on the expiry cycle beats the timeout.
    rst_pulse();
    send(8'h10);
    idle(7);
    send(8'h05);
    check("race_accepted", {22'd0, req_out, last_out, d_out}, {22'd0, 2'b10, 8'h05});
    idle(8);
    check("race_not_early", 32'(req_out), 32'd0);
    idle(1);
    check("race_trailer", {22'd0, req_out, last_out, d_out}, {22'd0, 2'b11, 8'hEB});
    idle(2);

    // Reset mid-packet discards it.
    rst_pulse();
    send(8'h11); send(8'h22);
    check("pre_reset_req", 32'(req_out), 32'd1);
    rst_pulse();
    send(8'h01); send(8'h01); send(8'h01); send(8'h01);
    idle(4);
    check("trailer_fc", 32'(last_trailer), 32'hFC);
    check("pkt_count_t6", 32'(pkt_count), 32'd1);

    // Randomized traffic with random gaps and downstream back-pressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(8'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 11)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ack_out = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ack_out = 1'b1;
    idle(30);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("pkt_count_final", 32'(pkt_count), 32'(exp_pkts % 65536));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
